// File: rtl/eth_rx_mac_filter_pkg.sv
// Shared definitions for the receive MAC address filter: FSM encodings, special
// addresses and the destination-match rule.
package eth_rx_mac_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  localparam logic [47:0] ETH_BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam int          ETH_IG_BIT        = 40;

  // Broadcast also has the I/G bit set, so it is excluded from the multicast term.
  function automatic logic mac_match(
    input logic [47:0] dest,
    input logic [47:0] stn_mac,
    input logic        promisc,
    input logic        bcast_en,
    input logic        mcast_en
  );
    logic is_bcast;
    is_bcast = (dest == ETH_BROADCAST_MAC);
    return promisc || (dest == stn_mac) || (bcast_en && is_bcast) ||
           (mcast_en && dest[ETH_IG_BIT] && !is_bcast);
  endfunction

endpackage

// File: rtl/eth_rx_mac_filter_if.sv
// Ethernet frame bundle: parsed header handshake plus AXI-stream payload.
// The master drives header/payload, the slave returns the two readies.
interface eth_rx_mac_filter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic                  hdr_valid;
  logic                  hdr_ready;
  logic [47:0]           dest_mac;
  logic [47:0]           src_mac;
  logic [15:0]           eth_type;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output hdr_valid, dest_mac, src_mac, eth_type, tdata, tkeep, tvalid, tlast, tuser,
    input  hdr_ready, tready
  );

  modport slave (
    input  hdr_valid, dest_mac, src_mac, eth_type, tdata, tkeep, tvalid, tlast, tuser,
    output hdr_ready, tready
  );
endinterface

// File: rtl/eth_rx_mac_filter_skid.sv
// Two-register payload output stage (output + temp), 1-cycle latency, full rate.
// o_tready_early is meant to be registered upstream; one in-flight beat lands in temp.
module eth_payload_skid #(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_tdata,
  input  logic [KEEP_WIDTH-1:0] i_tkeep,
  input  logic                  i_tvalid,
  input  logic                  i_tlast,
  input  logic                  i_tuser,
  output logic                  o_tready_early,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic [KEEP_WIDTH-1:0] o_tkeep,
  output logic                  o_tvalid,
  output logic                  o_tlast,
  output logic                  o_tuser,
  input  logic                  i_tready
);

  logic                  r_out_vld, r_tmp_vld, r_rdy;
  logic [DATA_WIDTH-1:0] r_out_dat, r_tmp_dat;
  logic [KEEP_WIDTH-1:0] r_out_keep, r_tmp_keep;
  logic                  r_out_last, r_tmp_last, r_out_user, r_tmp_user;
  logic                  w_out_vld_nxt, w_tmp_vld_nxt;
  logic                  w_in_to_out, w_in_to_tmp, w_tmp_to_out;
  logic [KEEP_WIDTH-1:0] w_keep;

  assign w_keep         = KEEP_ENABLE ? i_tkeep : {KEEP_WIDTH{1'b1}};
  // Ready is safe if the sink drains now, or if there is room for the beat already in flight.
  assign o_tready_early = i_tready || (!r_tmp_vld && (!r_out_vld || !i_tvalid));

  always_comb begin
    w_out_vld_nxt = r_out_vld;
    w_tmp_vld_nxt = r_tmp_vld;
    w_in_to_out   = 1'b0;
    w_in_to_tmp   = 1'b0;
    w_tmp_to_out  = 1'b0;
    if (r_rdy) begin
      if (i_tready || !r_out_vld) begin
        w_out_vld_nxt = i_tvalid;
        w_in_to_out   = 1'b1;
      end else begin
        w_tmp_vld_nxt = i_tvalid;
        w_in_to_tmp   = 1'b1;
      end
    end else if (i_tready) begin
      w_out_vld_nxt = r_tmp_vld;
      w_tmp_vld_nxt = 1'b0;
      w_tmp_to_out  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_tmp_vld <= 1'b0;
      r_rdy     <= 1'b0;
    end else begin
      r_out_vld <= w_out_vld_nxt;
      r_tmp_vld <= w_tmp_vld_nxt;
      r_rdy     <= o_tready_early;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_to_out) begin
      r_out_dat  <= i_tdata;
      r_out_keep <= w_keep;
      r_out_last <= i_tlast;
      r_out_user <= i_tuser;
    end else if (w_tmp_to_out) begin
      r_out_dat  <= r_tmp_dat;
      r_out_keep <= r_tmp_keep;
      r_out_last <= r_tmp_last;
      r_out_user <= r_tmp_user;
    end
    if (w_in_to_tmp) begin
      r_tmp_dat  <= i_tdata;
      r_tmp_keep <= w_keep;
      r_tmp_last <= i_tlast;
      r_tmp_user <= i_tuser;
    end
  end

  assign o_tdata  = r_out_dat;
  assign o_tkeep  = r_out_keep;
  assign o_tvalid = r_out_vld;
  assign o_tlast  = r_out_last;
  assign o_tuser  = r_out_user;

endmodule

// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter: matching frames forwarded (payload latency 1 cycle), others drained.
// Header held until m_eth.hdr_ready; payload backpressure via registered tready and skid buffer.
module eth_rx_mac_filter
  import eth_rx_mac_filter_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  eth_rx_mac_filter_if.slave   s_eth,
  eth_rx_mac_filter_if.master  m_eth,
  input  logic [47:0]          cfg_local_mac,
  input  logic                 cfg_promisc,
  input  logic                 cfg_broadcast_en,
  input  logic                 cfg_multicast_en,
  output logic [CNT_WIDTH-1:0] accept_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic                 busy
);

  state_t                r_state, w_state_nxt;
  logic                  r_hdr_ready, r_tready, r_m_hdr_valid, r_busy;
  logic [47:0]           r_dest_mac, r_src_mac;
  logic [15:0]           r_eth_type;
  logic [CNT_WIDTH-1:0]  r_accept_cnt, r_drop_cnt;
  logic                  w_hdr_fire, w_match, w_beat, w_last_fire, w_fwd_vld;
  logic                  w_early_rdy, w_m_hdr_valid_nxt, w_tready_nxt;

  assign w_hdr_fire  = (r_state == ST_IDLE) && s_eth.hdr_valid && r_hdr_ready;
  assign w_match     = mac_match(s_eth.dest_mac, cfg_local_mac, cfg_promisc,
                                 cfg_broadcast_en, cfg_multicast_en);
  assign w_beat      = s_eth.tvalid && r_tready;
  assign w_last_fire = w_beat && s_eth.tlast;
  assign w_fwd_vld   = w_beat && (r_state == ST_FORWARD);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:             if (w_hdr_fire)  w_state_nxt = w_match ? ST_FORWARD : ST_DROP;
      ST_FORWARD, ST_DROP: if (w_last_fire) w_state_nxt = ST_IDLE;
      default:             w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_m_hdr_valid_nxt = (w_hdr_fire && w_match) || (r_m_hdr_valid && !m_eth.hdr_ready);
  assign w_tready_nxt      = (w_state_nxt == ST_FORWARD) ? w_early_rdy : (w_state_nxt == ST_DROP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_hdr_ready   <= 1'b0;
      r_tready      <= 1'b0;
      r_m_hdr_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_accept_cnt  <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      // A new header is only offered once the previous one has been taken downstream.
      r_hdr_ready   <= (w_state_nxt == ST_IDLE) && !w_m_hdr_valid_nxt;
      r_tready      <= w_tready_nxt;
      r_m_hdr_valid <= w_m_hdr_valid_nxt;
      r_busy        <= (w_state_nxt != ST_IDLE);
      if (w_last_fire && (r_state == ST_FORWARD) && (r_accept_cnt != '1))
        r_accept_cnt <= r_accept_cnt + 1'b1;
      if (w_last_fire && (r_state == ST_DROP) && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hdr_fire && w_match) begin
      r_dest_mac <= s_eth.dest_mac;
      r_src_mac  <= s_eth.src_mac;
      r_eth_type <= s_eth.eth_type;
    end
  end

  eth_payload_skid #(
    .DATA_WIDTH  (DATA_WIDTH),
    .KEEP_ENABLE (KEEP_ENABLE),
    .KEEP_WIDTH  (KEEP_WIDTH)
  ) u_skid (
    .clk            (clk),
    .rst            (rst),
    .i_tdata        (s_eth.tdata),
    .i_tkeep        (s_eth.tkeep),
    .i_tvalid       (w_fwd_vld),
    .i_tlast        (s_eth.tlast),
    .i_tuser        (s_eth.tuser),
    .o_tready_early (w_early_rdy),
    .o_tdata        (m_eth.tdata),
    .o_tkeep        (m_eth.tkeep),
    .o_tvalid       (m_eth.tvalid),
    .o_tlast        (m_eth.tlast),
    .o_tuser        (m_eth.tuser),
    .i_tready       (m_eth.tready)
  );

  assign s_eth.hdr_ready = r_hdr_ready;
  assign s_eth.tready    = r_tready;
  assign m_eth.hdr_valid = r_m_hdr_valid;
  assign m_eth.dest_mac  = r_dest_mac;
  assign m_eth.src_mac   = r_src_mac;
  assign m_eth.eth_type  = r_eth_type;
  assign accept_count    = r_accept_cnt;
  assign drop_count      = r_drop_cnt;
  assign busy            = r_busy;

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed bench for eth_rx_mac_filter with a queue scoreboard and an independent output monitor.
module tb_eth_rx_mac_filter;

  localparam logic [47:0] MAC_LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] MAC_OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] MAC_MCAST = 48'h01_00_5E_00_00_01;
  localparam logic [47:0] MAC_BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MAC_SRC   = 48'h02_00_00_00_00_AA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] cfg_local_mac = MAC_LOCAL;
  logic        cfg_promisc = 1'b0, cfg_broadcast_en = 1'b0, cfg_multicast_en = 1'b0;
  logic [3:0]  accept_count, drop_count;
  logic        busy;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b1;
  bit bp = 1'b0;

  logic [111:0] hq[$];
  logic [9:0]   bq[$];

  eth_rx_mac_filter_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1)) s_if();
  eth_rx_mac_filter_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1)) m_if();

  eth_rx_mac_filter #(
    .DATA_WIDTH(8), .KEEP_ENABLE(1'b0), .KEEP_WIDTH(1), .CNT_WIDTH(4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .s_eth            (s_if),
    .m_eth            (m_if),
    .cfg_local_mac    (cfg_local_mac),
    .cfg_promisc      (cfg_promisc),
    .cfg_broadcast_en (cfg_broadcast_en),
    .cfg_multicast_en (cfg_multicast_en),
    .accept_count     (accept_count),
    .drop_count       (drop_count),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Sink readies: always ready, or randomly throttled during the backpressure phase.
  initial begin
    m_if.tready    = 1'b1;
    m_if.hdr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_if.tready    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      m_if.hdr_ready = bp ? ($urandom_range(0, 3) == 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [111:0] eh;
    logic [9:0]   eb;
    if (!rst && mon_en) begin
      if (s_if.hdr_valid && s_if.hdr_ready)
        chk("hdr_while_pending", m_if.hdr_valid, 0);
      if (m_if.hdr_valid && m_if.hdr_ready) begin
        if (hq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_hdr actual dest=%0h expected none", m_if.dest_mac);
        end else begin
          eh = hq.pop_front();
          chk("hdr_dest", m_if.dest_mac, eh[111:64]);
          chk("hdr_src",  m_if.src_mac,  eh[63:16]);
          chk("hdr_type", m_if.eth_type, eh[15:0]);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        if (bq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual data=%0h expected none", m_if.tdata);
        end else begin
          eb = bq.pop_front();
          chk("beat_data", m_if.tdata, eb[9:2]);
          chk("beat_last", m_if.tlast, eb[1]);
          chk("beat_user", m_if.tuser, eb[0]);
          chk("beat_keep", m_if.tkeep, 1'b1);
        end
      end
    end
  end

  task automatic drive_hdr(input logic [47:0] dest, input logic [7:0] seed);
    int n = 0;
    s_if.dest_mac  = dest;
    s_if.src_mac   = MAC_SRC;
    s_if.eth_type  = {8'h08, seed};
    s_if.hdr_valid = 1'b1;
    @(negedge clk);
    while (!s_if.hdr_ready && n < 500) begin @(negedge clk); n++; end
    if (!s_if.hdr_ready) begin
      checks++; failures++;
      $display("FAIL hdr_timeout actual ready=0 expected ready=1");
    end
    @(posedge clk); #1;
    s_if.hdr_valid = 1'b0;
  endtask

  task automatic wait_beat(output int waited);
    waited = 0;
    @(negedge clk);
    while (!s_if.tready && waited < 500) begin @(negedge clk); waited++; end
    if (!s_if.tready) begin
      checks++; failures++;
      $display("FAIL beat_timeout actual tready=0 expected tready=1");
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_payload(input int len, input logic [7:0] seed, input logic user,
                               output int stalls);
    int w;
    stalls = 0;
    for (int i = 0; i < len; i++) begin
      s_if.tdata  = seed + 8'(i);
      s_if.tlast  = (i == len - 1);
      s_if.tuser  = user && (i == len - 1);
      s_if.tvalid = 1'b1;
      wait_beat(w);
      if (i > 0) stalls += w;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] dest, input int len, input logic [7:0] seed,
                            input logic user, input logic fwd, output int stalls);
    logic [7:0] d;
    if (fwd) begin
      hq.push_back({dest, MAC_SRC, 8'h08, seed});
      for (int i = 0; i < len; i++) begin
        d = seed + 8'(i);
        bq.push_back({d, (i == len - 1), (user && (i == len - 1))});
      end
    end
    fork
      drive_hdr(dest, seed);
      drive_payload(len, seed, user, stalls);
    join
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((hq.size() != 0 || bq.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_pending", 64'(hq.size() + bq.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_hdr_ready"}, s_if.hdr_ready, 0);
    chk({tag, "_s_tready"},    s_if.tready, 0);
    chk({tag, "_m_hdr_valid"}, m_if.hdr_valid, 0);
    chk({tag, "_m_tvalid"},    m_if.tvalid, 0);
    chk({tag, "_busy"},        busy, 0);
    chk({tag, "_accept"},      accept_count, 0);
    chk({tag, "_drop"},        drop_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    s_if.hdr_valid = 1'b0;
    s_if.dest_mac  = '0;
    s_if.src_mac   = '0;
    s_if.eth_type  = '0;
    s_if.tdata     = '0;
    s_if.tkeep     = 1'b1;
    s_if.tvalid    = 1'b0;
    s_if.tlast     = 1'b0;
    s_if.tuser     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Exact unicast match, 46-byte payload.
    send_frame(MAC_LOCAL, 46, 8'h10, 1'b0, 1'b1, st);
    wait_drain();
    chk("exact_accept", accept_count, 1);
    chk("exact_drop", drop_count, 0);

    // Other unicast and disabled broadcast are drained at full rate.
    send_frame(MAC_OTHER, 20, 8'h30, 1'b0, 1'b0, st);
    chk("drop_other_rate", st, 0);
    send_frame(MAC_BCAST, 12, 8'h40, 1'b0, 1'b0, st);
    chk("drop_bcast_rate", st, 0);
    wait_drain();
    chk("filtered_drop", drop_count, 2);
    chk("filtered_accept", accept_count, 1);

    // Multicast enable admits group addresses but not broadcast.
    cfg_multicast_en = 1'b1;
    send_frame(MAC_MCAST, 16, 8'h50, 1'b0, 1'b1, st);
    send_frame(MAC_BCAST, 8, 8'h58, 1'b0, 1'b0, st);
    cfg_broadcast_en = 1'b1;
    send_frame(MAC_BCAST, 16, 8'h60, 1'b0, 1'b1, st);
    wait_drain();
    chk("mcbc_accept", accept_count, 3);
    chk("mcbc_drop", drop_count, 3);
    cfg_multicast_en = 1'b0;
    cfg_broadcast_en = 1'b0;

    // Random sink backpressure over back-to-back frames.
    bp = 1'b1;
    send_frame(MAC_LOCAL, 64, 8'h00, 1'b0, 1'b1, st);
    send_frame(MAC_LOCAL, 64, 8'h40, 1'b1, 1'b1, st);
    send_frame(MAC_LOCAL, 64, 8'h80, 1'b0, 1'b1, st);
    wait_drain();
    bp = 1'b0;
    chk("bp_accept", accept_count, 6);

    // Single-beat frame with tuser set.
    send_frame(MAC_LOCAL, 1, 8'hC5, 1'b1, 1'b1, st);
    wait_drain();
    chk("onebeat_accept", accept_count, 7);

    // Drop counter saturation.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int f = 0; f < 17; f++) begin
      send_frame(MAC_OTHER, 2, 8'(f), 1'b0, 1'b0, st);
      if (f == 14) begin
        @(posedge clk); #1;
        chk("sat_drop_15", drop_count, 15);
      end
    end
    wait_drain();
    chk("sat_drop_17", drop_count, 15);
    chk("sat_accept", accept_count, 0);

    // Reset during beat 10 of a forwarded frame.
    mon_en = 1'b0;
    fork
      drive_hdr(MAC_LOCAL, 8'h90);
      begin
        for (int i = 0; i < 9; i++) begin
          s_if.tdata  = 8'h90 + 8'(i);
          s_if.tlast  = 1'b0;
          s_if.tvalid = 1'b1;
          wait_beat(st);
        end
      end
    join
    s_if.tdata  = 8'h99;
    s_if.tvalid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    s_if.tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    hq.delete();
    bq.delete();
    mon_en = 1'b1;
    @(posedge clk); #1;
    send_frame(MAC_LOCAL, 24, 8'hA0, 1'b0, 1'b1, st);
    wait_drain();
    chk("post_rst_accept", accept_count, 1);
    chk("post_rst_drop", drop_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
